// File: rtl/ftq_if.sv
// Fetch-target-queue bus: BPU enqueue, backend read/writeback/commit/squash,
// occupancy, and the BPU training update.
interface ftq_if #(
    parameter int DEPTH   = 16,
    parameter int BRU_NUM = 2,
    parameter int XLEN    = 64
);
    localparam int IDXW = $clog2(DEPTH);

    logic                             i_enq_vld;
    logic                             o_enq_rdy;
    logic [XLEN-1:0]                  i_enq_startAddr;
    logic [XLEN-1:0]                  i_enq_nextAddr;
    logic [IDXW-1:0]                  o_enq_ftqIdx;

    logic [BRU_NUM-1:0][IDXW-1:0]     i_read_ftqIdx;
    logic [BRU_NUM-1:0][XLEN-1:0]     o_read_ftqStartAddr;
    logic [BRU_NUM-1:0][XLEN-1:0]     o_read_ftqNextAddr;

    logic [BRU_NUM-1:0]               i_branchwb_vld;
    logic [BRU_NUM-1:0][IDXW-1:0]     i_branchwb_ftqIdx;
    logic [BRU_NUM-1:0]               i_branchwb_mispred;
    logic [BRU_NUM-1:0][XLEN-1:0]     i_branchwb_target;

    logic                             i_commit_vld;
    logic [IDXW-1:0]                  i_commit_ftqIdx;
    logic                             i_squash_vld;
    logic [IDXW-1:0]                  i_squash_ftqIdx;

    logic [IDXW:0]                    o_count;
    logic                             o_upd_vld;
    logic [XLEN-1:0]                  o_upd_startAddr;
    logic [XLEN-1:0]                  o_upd_target;
    logic                             o_upd_mispred;
    logic                             o_commit_err;

    modport master (
        output i_enq_vld, i_enq_startAddr, i_enq_nextAddr, i_read_ftqIdx,
               i_branchwb_vld, i_branchwb_ftqIdx, i_branchwb_mispred, i_branchwb_target,
               i_commit_vld, i_commit_ftqIdx, i_squash_vld, i_squash_ftqIdx,
        input  o_enq_rdy, o_enq_ftqIdx, o_read_ftqStartAddr, o_read_ftqNextAddr,
               o_count, o_upd_vld, o_upd_startAddr, o_upd_target, o_upd_mispred, o_commit_err
    );

    modport slave (
        input  i_enq_vld, i_enq_startAddr, i_enq_nextAddr, i_read_ftqIdx,
               i_branchwb_vld, i_branchwb_ftqIdx, i_branchwb_mispred, i_branchwb_target,
               i_commit_vld, i_commit_ftqIdx, i_squash_vld, i_squash_ftqIdx,
        output o_enq_rdy, o_enq_ftqIdx, o_read_ftqStartAddr, o_read_ftqNextAddr,
               o_count, o_upd_vld, o_upd_startAddr, o_upd_target, o_upd_mispred, o_commit_err
    );
endinterface

// File: rtl/ftq.sv
// Fetch target queue: circular buffer of predicted fetch blocks between the
// BPU and the backend, with branch resolution, in-order commit and squash.
module ftq #(
    parameter int DEPTH   = 16,
    parameter int BRU_NUM = 2,
    parameter int XLEN    = 64
) (
    input  logic  clk,
    input  logic  rst,
    ftq_if.slave  bus
);
    localparam int IDXW = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] start_addr;
        logic [XLEN-1:0] next_addr;
        logic [XLEN-1:0] target;
        logic            resolved;
        logic            mispred;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;

    // Pointers carry the wrap flag in the MSB.
    logic [IDXW:0]   head_q, head_d, tail_q, tail_d, count_q, count_d, occ;
    logic            upd_vld_q, upd_mispred_q, err_q;
    logic [XLEN-1:0] upd_start_q, upd_target_q;

    logic [IDXW-1:0] head_idx, tail_idx, sq_off;
    logic [DEPTH-1:0] squashed;
    logic            full, empty, enq_fire, commit_ok, sq_ok, err_set;

    assign head_idx = head_q[IDXW-1:0];
    assign tail_idx = tail_q[IDXW-1:0];
    assign occ      = tail_q - head_q;
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IDXW] != tail_q[IDXW]);

    assign bus.o_enq_rdy    = !full && !bus.i_squash_vld;
    assign bus.o_enq_ftqIdx = tail_idx;
    assign enq_fire         = bus.i_enq_vld && bus.o_enq_rdy;

    assign commit_ok = bus.i_commit_vld && !empty && (bus.i_commit_ftqIdx == head_idx);
    // Offset of the youngest survivor from head; valid only if it lies within occupancy.
    assign sq_off    = bus.i_squash_ftqIdx - head_idx;
    assign sq_ok     = bus.i_squash_vld && ({1'b0, sq_off} < occ);
    assign err_set   = (bus.i_commit_vld && !commit_ok) || (bus.i_squash_vld && !sq_ok);

    // Next head/tail/count; a squash rebuilds tail from head so the flag comes out right.
    always_comb begin
        head_d = commit_ok ? head_q + 1'b1 : head_q;
        if (sq_ok)         tail_d = head_q + {1'b0, sq_off} + 1'b1;
        else if (enq_fire) tail_d = tail_q + 1'b1;
        else               tail_d = tail_q;
        count_d = tail_d - head_d;
    end

    // Entries younger than the squash point are discarded this cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            squashed[i] = sq_ok && ((IDXW'(i) - head_idx) > sq_off);
        end
    end

    // Per-entry update: writeback, commit, squash and enqueue.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        valid_d = valid_q;
        ent_d   = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            // NOTE: blocking writes in descending port order let the lowest
            // mispredicting port land last and win.
            for (int p = BRU_NUM-1; p >= 0; p--) begin
                if (bus.i_branchwb_vld[p] && (bus.i_branchwb_ftqIdx[p] == IDXW'(i)) &&
                    valid_q[i] && !squashed[i]) begin
                    ent_d[i].resolved = 1'b1;
                    if (bus.i_branchwb_mispred[p]) begin
                        ent_d[i].mispred = 1'b1;
                        ent_d[i].target  = bus.i_branchwb_target[p];
                    end
                end
            end
            if (commit_ok && (head_idx == IDXW'(i))) valid_d[i] = 1'b0;
            if (squashed[i])                          valid_d[i] = 1'b0;
            if (enq_fire && (tail_idx == IDXW'(i))) begin
                valid_d[i] = 1'b1;
                ent_d[i]   = '{start_addr: bus.i_enq_startAddr,
                               next_addr:  bus.i_enq_nextAddr,
                               default:    '0};
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            upd_vld_q     <= 1'b0;
            upd_start_q   <= '0;
            upd_target_q  <= '0;
            upd_mispred_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            upd_vld_q <= commit_ok;
            if (commit_ok) begin
                upd_start_q   <= ent_q[head_idx].start_addr;
                upd_target_q  <= ent_q[head_idx].mispred ? ent_q[head_idx].target
                                                         : ent_q[head_idx].next_addr;
                upd_mispred_q <= ent_q[head_idx].mispred;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    // Entry payload storage.
    // NOTE: payload is not reset; the valid bits alone decide whether it matters.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    // Zero-latency backend read ports.
    always_comb begin
        for (int p = 0; p < BRU_NUM; p++) begin
            bus.o_read_ftqStartAddr[p] = ent_q[bus.i_read_ftqIdx[p]].start_addr;
            bus.o_read_ftqNextAddr[p]  = ent_q[bus.i_read_ftqIdx[p]].next_addr;
        end
    end

    assign bus.o_count         = count_q;
    assign bus.o_upd_vld       = upd_vld_q;
    assign bus.o_upd_startAddr = upd_start_q;
    assign bus.o_upd_target    = upd_target_q;
    assign bus.o_upd_mispred   = upd_mispred_q;
    assign bus.o_commit_err    = err_q;
endmodule

// File: tb/tb_ftq.sv
// Testbench for ftq: vector table, directed corner sequences, and random
// stimulus checked against a queue-based reference model.
module tb_ftq;
    localparam int DEPTH = 16;
    localparam int BRU   = 2;
    localparam int XLEN  = 64;
    localparam int IDXW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ftq_if #(.DEPTH(DEPTH), .BRU_NUM(BRU), .XLEN(XLEN)) bus();
    ftq #(.DEPTH(DEPTH), .BRU_NUM(BRU), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] st;
        logic [63:0] nx;
        logic [63:0] tg;
        bit          mis;
    } ment_t;

    ment_t       mq[$];
    int          hd;
    bit          e_uv, e_um, e_err;
    logic [63:0] e_us, e_ut;
    logic [63:0] mem_st [DEPTH];
    logic [63:0] mem_nx [DEPTH];
    bit          mem_w  [DEPTH];

    task automatic model_reset();
        mq.delete();
        hd = 0; e_uv = 0; e_um = 0; e_us = '0; e_ut = '0; e_err = 0;
    endtask

    task automatic model_step();
        int  sz    = mq.size();
        int  tl    = (hd + sz) % DEPTH;
        bit  enq   = bus.i_enq_vld && (sz < DEPTH) && !bus.i_squash_vld;
        bit  c_ok  = bus.i_commit_vld && (sz > 0) && (int'(bus.i_commit_ftqIdx) == hd);
        int  s_off = (int'(bus.i_squash_ftqIdx) - hd + DEPTH) % DEPTH;
        bit  s_ok  = bus.i_squash_vld && (s_off < sz);
        bit  taken [DEPTH];
        ment_t e;
        foreach (taken[k]) taken[k] = 0;
        e_uv = c_ok;
        if (c_ok) begin
            e_us = mq[0].st;
            e_ut = mq[0].mis ? mq[0].tg : mq[0].nx;
            e_um = mq[0].mis;
        end
        for (int p = 0; p < BRU; p++) begin
            int off = (int'(bus.i_branchwb_ftqIdx[p]) - hd + DEPTH) % DEPTH;
            if (bus.i_branchwb_vld[p] && bus.i_branchwb_mispred[p] && off < sz &&
                !(s_ok && off > s_off) && !taken[off]) begin
                taken[off]  = 1;
                mq[off].mis = 1;
                mq[off].tg  = bus.i_branchwb_target[p];
            end
        end
        if (s_ok) while (mq.size() > s_off + 1) void'(mq.pop_back());
        if (c_ok) begin
            void'(mq.pop_front());
            hd = (hd + 1) % DEPTH;
        end
        if (enq) begin
            e.st = bus.i_enq_startAddr; e.nx = bus.i_enq_nextAddr; e.tg = '0; e.mis = 0;
            mq.push_back(e);
            mem_st[tl] = e.st; mem_nx[tl] = e.nx; mem_w[tl] = 1;
        end
        if ((bus.i_commit_vld && !c_ok) || (bus.i_squash_vld && !s_ok)) e_err = 1;
    endtask

    task automatic check_outputs();
        int sz = mq.size();
        check("enq_rdy", bus.o_enq_rdy, (sz < DEPTH) && !bus.i_squash_vld);
        check("enq_idx", bus.o_enq_ftqIdx, (hd + sz) % DEPTH);
        check("count", bus.o_count, sz);
        check("upd_vld", bus.o_upd_vld, e_uv);
        if (e_uv) begin
            check("upd_start", bus.o_upd_startAddr, e_us);
            check("upd_target", bus.o_upd_target, e_ut);
            check("upd_mispred", bus.o_upd_mispred, e_um);
        end
        check("commit_err", bus.o_commit_err, e_err);
        for (int p = 0; p < BRU; p++) begin
            int idx = int'(bus.i_read_ftqIdx[p]);
            if (mem_w[idx]) begin
                check($sformatf("read%0d_start[%0d]", p, idx), bus.o_read_ftqStartAddr[p], mem_st[idx]);
                check($sformatf("read%0d_next[%0d]", p, idx), bus.o_read_ftqNextAddr[p], mem_nx[idx]);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        bus.i_enq_vld = 0; bus.i_enq_startAddr = '0; bus.i_enq_nextAddr = '0;
        bus.i_read_ftqIdx = '0;
        bus.i_branchwb_vld = '0; bus.i_branchwb_ftqIdx = '0;
        bus.i_branchwb_mispred = '0; bus.i_branchwb_target = '0;
        bus.i_commit_vld = 0; bus.i_commit_ftqIdx = '0;
        bus.i_squash_vld = 0; bus.i_squash_ftqIdx = '0;
    endtask

    // One clock: check outputs against the model, advance both, return idle.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        set_idle();
        #1;
    endtask

    task automatic drive_enq(input logic [63:0] s, input logic [63:0] n);
        bus.i_enq_vld = 1; bus.i_enq_startAddr = s; bus.i_enq_nextAddr = n;
    endtask

    task automatic drive_commit(input int idx);
        bus.i_commit_vld = 1; bus.i_commit_ftqIdx = IDXW'(idx);
    endtask

    task automatic drive_squash(input int idx);
        bus.i_squash_vld = 1; bus.i_squash_ftqIdx = IDXW'(idx);
    endtask

    task automatic drive_bwb(input int p, input int idx, input bit mis, input logic [63:0] tgt);
        bus.i_branchwb_vld[p] = 1; bus.i_branchwb_ftqIdx[p] = IDXW'(idx);
        bus.i_branchwb_mispred[p] = mis; bus.i_branchwb_target[p] = tgt;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        model_reset();
        #2;
        check("rst_count", bus.o_count, 0);
        check("rst_upd_vld", bus.o_upd_vld, 0);
        check("rst_upd_start", bus.o_upd_startAddr, 0);
        check("rst_upd_target", bus.o_upd_target, 0);
        check("rst_upd_mispred", bus.o_upd_mispred, 0);
        check("rst_err", bus.o_commit_err, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        check("rst_enq_rdy", bus.o_enq_rdy, 1);
        check("rst_enq_idx", bus.o_enq_ftqIdx, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit enq;
        bit cv;
        int ci;
        bit sv;
        int si;
        int e_cnt;
        int e_tail;
        bit e_err;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1, 0, 0, 0, 0, 1, 1, 0};
        tbl[1] = '{1, 0, 0, 0, 0, 2, 2, 0};
        tbl[2] = '{1, 1, 0, 0, 0, 2, 3, 0};
        tbl[3] = '{1, 0, 0, 0, 0, 3, 4, 0};
        tbl[4] = '{0, 0, 0, 1, 2, 2, 3, 0};
        tbl[5] = '{0, 1, 1, 1, 2, 1, 3, 0};
        tbl[6] = '{0, 0, 0, 1, 0, 1, 3, 1};
        tbl[7] = '{0, 1, 2, 0, 0, 0, 3, 1};
        tbl[8] = '{0, 1, 3, 0, 0, 0, 3, 1};
        foreach (mem_w[k]) mem_w[k] = 0;
        set_idle();
        do_reset();

        // Table-driven sequence
        for (int k = 0; k < 9; k++) begin
            if (tbl[k].enq) drive_enq(64'h3000 + 64'(k) * 64'h10, 64'h3000 + 64'(k) * 64'h10 + 64'h8);
            if (tbl[k].cv)  drive_commit(tbl[k].ci);
            if (tbl[k].sv)  drive_squash(tbl[k].si);
            cycle();
            check($sformatf("vec%0d_count", k), bus.o_count, tbl[k].e_cnt);
            check($sformatf("vec%0d_tail", k), bus.o_enq_ftqIdx, tbl[k].e_tail);
            check($sformatf("vec%0d_err", k), bus.o_commit_err, tbl[k].e_err);
        end

        // Fill to full, read idx 5, enqueue refused while full
        do_reset();
        for (int n = 0; n < 16; n++) begin
            drive_enq(64'h1000 + 64'(n) * 64'h10, 64'h1010 + 64'(n) * 64'h10);
            cycle();
        end
        check("full_rdy", bus.o_enq_rdy, 0);
        check("full_count", bus.o_count, 16);
        bus.i_read_ftqIdx[0] = 4'd5;
        #1;
        check("read5_start", bus.o_read_ftqStartAddr[0], 64'h1050);
        drive_enq(64'hdead, 64'hbeef);
        cycle();
        check("full_enq_blocked", bus.o_count, 16);

        // Drain all 16, enqueue 4 across the wrap, then refill to full
        for (int n = 0; n < 16; n++) begin
            drive_commit(n);
            cycle();
        end
        check("drain_count", bus.o_count, 0);
        for (int n = 0; n < 4; n++) begin
            drive_enq(64'h2000 + 64'(n) * 64'h10, 64'h2008 + 64'(n) * 64'h10);
            cycle();
        end
        check("wrap_count", bus.o_count, 4);
        check("wrap_tail", bus.o_enq_ftqIdx, 4);
        bus.i_read_ftqIdx[0] = 4'd0;
        bus.i_read_ftqIdx[1] = 4'd3;
        #1;
        check("wrap_read0", bus.o_read_ftqStartAddr[0], 64'h2000);
        check("wrap_read3", bus.o_read_ftqNextAddr[1], 64'h2038);
        for (int n = 4; n < 16; n++) begin
            drive_enq(64'h2000 + 64'(n) * 64'h10, 64'h2008 + 64'(n) * 64'h10);
            cycle();
        end
        check("wrap_full_rdy", bus.o_enq_rdy, 0);

        // Mispredict writeback, both ports on one entry, then commits
        do_reset();
        for (int n = 0; n < 3; n++) begin
            drive_enq(64'h100 * 64'(n + 1), 64'h100 * 64'(n + 1) + 64'h4);
            cycle();
        end
        drive_bwb(0, 1, 1, 64'h8000);
        drive_bwb(1, 1, 1, 64'h9000);
        cycle();
        drive_commit(0);
        cycle();
        check("c0_upd_vld", bus.o_upd_vld, 1);
        check("c0_upd_start", bus.o_upd_startAddr, 64'h100);
        check("c0_upd_target", bus.o_upd_target, 64'h104);
        check("c0_upd_mispred", bus.o_upd_mispred, 0);
        drive_commit(1);
        cycle();
        check("c1_upd_start", bus.o_upd_startAddr, 64'h200);
        check("c1_upd_target", bus.o_upd_target, 64'h8000);
        check("c1_upd_mispred", bus.o_upd_mispred, 1);
        cycle();
        check("c1_upd_vld_drop", bus.o_upd_vld, 0);

        // Squash with a same-cycle writeback to a squashed entry
        do_reset();
        for (int n = 0; n < 8; n++) begin
            drive_enq(64'h400 + 64'(n) * 64'h10, 64'h410 + 64'(n) * 64'h10);
            cycle();
        end
        drive_squash(2);
        drive_bwb(0, 5, 1, 64'hdead);
        cycle();
        check("sq_count", bus.o_count, 3);
        check("sq_tail", bus.o_enq_ftqIdx, 3);
        check("sq_rdy", bus.o_enq_rdy, 1);
        for (int n = 0; n < 3; n++) begin
            drive_enq(64'h900 + 64'(n) * 64'h10, 64'h910 + 64'(n) * 64'h10);
            cycle();
        end
        for (int n = 0; n < 6; n++) begin
            drive_commit(n);
            cycle();
        end
        check("sq5_upd_target", bus.o_upd_target, 64'h930);
        check("sq5_upd_mispred", bus.o_upd_mispred, 0);

        // Bad commit, good commit, then reset mid-stream
        do_reset();
        drive_enq(64'h500, 64'h510);
        cycle();
        drive_enq(64'h600, 64'h610);
        cycle();
        drive_commit(2);
        cycle();
        check("bad_commit_err", bus.o_commit_err, 1);
        check("bad_commit_count", bus.o_count, 2);
        drive_commit(0);
        cycle();
        check("good_commit_start", bus.o_upd_startAddr, 64'h500);
        do_reset();

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int sz = mq.size();
            if ($urandom_range(99) < 55)
                drive_enq({$urandom, $urandom}, {$urandom, $urandom});
            if (sz > 0 && $urandom_range(99) < 35) drive_commit(hd);
            else if ($urandom_range(199) == 0)     drive_commit(int'($urandom_range(DEPTH-1)));
            if ($urandom_range(99) < 4) begin
                if (sz > 0 && $urandom_range(9) != 0) drive_squash((hd + int'($urandom_range(sz-1))) % DEPTH);
                else                                  drive_squash(int'($urandom_range(DEPTH-1)));
            end
            for (int p = 0; p < BRU; p++) begin
                if ($urandom_range(99) < 30) begin
                    int bi = (sz > 0) ? (hd + int'($urandom_range(sz-1))) % DEPTH
                                      : int'($urandom_range(DEPTH-1));
                    drive_bwb(p, bi, 1'($urandom_range(1)), {$urandom, $urandom});
                end
                bus.i_read_ftqIdx[p] = IDXW'($urandom_range(DEPTH-1));
            end
            cycle();
            if ($urandom_range(599) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
